// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle barrel-free shifter. One operation is
// captured on Start, then ShiftedB walks one bit position per clock (or two
// per clock when ITERATIVE_SHIFTER_FAST2_EN is defined) until the captured
// distance is consumed. Results are identical in both builds; only the
// latency differs.
// Optional feature macro: ITERATIVE_SHIFTER_FAST2_EN
module iterative_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        ShiftSelect,
    input  logic [AMT_W-1:0]  ShifterAmount,
    input  logic [WIDTH-1:0]  OriginB,
    output logic [WIDTH-1:0]  ShiftedB,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);
    localparam logic [AMT_W-1:0] TWO = AMT_W'(2);

    state_t             state, state_d;
    logic [2:0]         sel_q;
    logic [AMT_W-1:0]   cnt;
    logic [WIDTH-1:0]   shifted_b;
    logic               accept;
    logic               last_step;

    // Single-position move for the captured operation; 101-111 hold the value.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                               input logic [2:0] s);
        logic [WIDTH-1:0] r;
        r = v;
        case (s)
            3'b000:  r = {1'b0, v[WIDTH-1:1]};
            3'b001:  r = {v[WIDTH-2:0], 1'b0};
            3'b010:  r = {v[0], v[WIDTH-1:1]};
            3'b011:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b100:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // A new request is only taken when not mid-shift.
    assign accept = Start && (state != SHIFT);

`ifdef ITERATIVE_SHIFTER_FAST2_EN
    // Two positions per edge consume the count in pairs; the final edge is
    // the one that leaves 0 (count of 1 or 2 going in).
    assign last_step = (cnt <= TWO);
`else
    assign last_step = (cnt == ONE);
`endif

    // Next-state and status outputs.
    always_comb begin
        state_d = state;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state)
            IDLE, DONE: begin
                Done = (state == DONE);
                if (Start) begin
                    // Zero distance or pass-through select completes at capture.
                    if (ShifterAmount == '0 || ShiftSelect > 3'b100)
                        state_d = DONE;
                    else
                        state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_step)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, capture registers and the shifting datapath.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            sel_q     <= '0;
            cnt       <= '0;
            shifted_b <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                sel_q     <= ShiftSelect;
                cnt       <= ShifterAmount;
                shifted_b <= OriginB;
            end else if (state == SHIFT) begin
`ifdef ITERATIVE_SHIFTER_FAST2_EN
                if (cnt > ONE) begin
                    shifted_b <= step1(step1(shifted_b, sel_q), sel_q);
                    cnt       <= cnt - TWO;
                end else begin
                    shifted_b <= step1(shifted_b, sel_q);
                    cnt       <= cnt - ONE;
                end
`else
                shifted_b <= step1(shifted_b, sel_q);
                cnt       <= cnt - ONE;
`endif
            end
        end
    end

    assign ShiftedB = shifted_b;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed table, hand sequences
// for back-to-back / held Start / reset abort, and randomized operations
// compared against an arithmetic reference model.
module tb_iterative_shifter;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

`ifdef ITERATIVE_SHIFTER_FAST2_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [2:0]        ShiftSelect;
    logic [AMT_W-1:0]  ShifterAmount;
    logic [WIDTH-1:0]  OriginB;
    logic [WIDTH-1:0]  ShiftedB;
    logic              Busy;
    logic              Done;

    int n_checks = 0;
    int n_fail   = 0;

    iterative_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ShiftSelect(ShiftSelect),
        .ShifterAmount(ShifterAmount), .OriginB(OriginB),
        .ShiftedB(ShiftedB), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] b;
        int          sa;
        logic [2:0]  sel;
        logic [15:0] exp_res;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on the whole distance at once.
    function automatic logic [15:0] ref_shift(input logic [15:0] b, input int sa,
                                              input logic [2:0] sel);
        logic [15:0] r;
        case (sel)
            3'd0: r = b >> sa;
            3'd1: r = b << sa;
            3'd2: r = (sa == 0) ? b : ((b >> sa) | (b << (16 - sa)));
            3'd3: r = (sa == 0) ? b : ((b << sa) | (b >> (16 - sa)));
            3'd4: r = 16'($signed(b) >>> sa);
            default: r = b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input int sa, input logic [2:0] sel);
        if (sel > 3'd4 || sa == 0) return 0;
        return FAST ? (sa + 1) / 2 : sa;
    endfunction

    task automatic drive_req(input logic [15:0] b, input int sa, input logic [2:0] sel);
        Start = 1'b1; OriginB = b; ShifterAmount = AMT_W'(sa); ShiftSelect = sel;
    endtask

    // Wait (bounded) for Done, counting edges and Busy cycles. Called #1
    // after the capture edge.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!Done && lat < 40) begin
            busy_n += int'(Busy);
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    // Full operation: capture, scramble inputs, wait for completion.
    task automatic do_op(input logic [15:0] b, input int sa, input logic [2:0] sel,
                         output logic [15:0] res, output int lat, output int busy_n);
        @(negedge Clk);
        drive_req(b, sa, sel);
        @(posedge Clk); #1;
        Start = 1'b0;
        OriginB = 16'($urandom); ShifterAmount = AMT_W'($urandom); ShiftSelect = 3'($urandom);
        wait_done(lat, busy_n);
        res = ShiftedB;
    endtask

    task automatic op_and_check(input string nm, input logic [15:0] b, input int sa,
                                input logic [2:0] sel, input logic [15:0] exp_res);
        logic [15:0] res;
        int lat, bn;
        do_op(b, sa, sel, res, lat, bn);
        check({nm, " result"}, int'(res), int'(exp_res));
        check({nm, " latency"}, lat, ref_lat(sa, sel));
        check({nm, " busy_cycles"}, bn, ref_lat(sa, sel));
        @(posedge Clk); #1;
        check({nm, " done_pulse_1cyc"}, int'(Done), 0);
        check({nm, " hold_idle"}, int'(ShiftedB), int'(exp_res));
    endtask

    initial begin
        vec_t vecs[$];
        logic [15:0] res;
        int lat, bn;
        int saw_done;

        Reset = 1'b1; Start = 1'b1; ShiftSelect = 3'd1;
        ShifterAmount = 4'd3; OriginB = 16'hBEEF;
        repeat (3) @(posedge Clk);
        #1;
        check("reset ShiftedB", int'(ShiftedB), 0);
        check("reset Busy", int'(Busy), 0);
        check("reset Done", int'(Done), 0);
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;

        // Directed table.
        vecs.push_back('{16'hD000, 15, 3'b000, 16'h0001});
        vecs.push_back('{16'hD000, 15, 3'b001, 16'h0000});
        vecs.push_back('{16'hD000, 15, 3'b010, 16'hA001});
        vecs.push_back('{16'hD000, 15, 3'b011, 16'h6800});
        vecs.push_back('{16'hD000, 15, 3'b100, 16'hFFFF});
        vecs.push_back('{16'h1234,  0, 3'b110, 16'h1234});
        vecs.push_back('{16'h1234,  4, 3'b111, 16'h1234});
        vecs.push_back('{16'h00FF,  0, 3'b001, 16'h00FF});
        vecs.push_back('{16'h8001,  1, 3'b010, 16'hC000});
        vecs.push_back('{16'h8001,  1, 3'b011, 16'h0003});
        vecs.push_back('{16'h8000,  3, 3'b100, 16'hF000});
        vecs.push_back('{16'h1234,  4, 3'b000, 16'h0123});
        vecs.push_back('{16'h1234,  8, 3'b011, 16'h3412});
        foreach (vecs[i])
            op_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].sa, vecs[i].sel,
                         vecs[i].exp_res);

        // Start held high with changing operands while shifting is ignored.
        @(negedge Clk);
        drive_req(16'hD000, 15, 3'b000);
        @(posedge Clk); #1;
        drive_req(16'hFFFF, 2, 3'b001);
        wait_done(lat, bn);
        Start = 1'b0;
        check("held_start result", int'(ShiftedB), 16'h0001);
        check("held_start latency", lat, ref_lat(15, 3'b000));
        @(posedge Clk); #1;
        check("held_start done_drop", int'(Done), 0);

        // Back-to-back: new request presented while Done is high.
        do_op(16'h1234, 2, 3'b000, res, lat, bn);
        drive_req(16'h0001, 1, 3'b001);
        @(posedge Clk); #1;
        Start = 1'b0;
        check("b2b done_drop", int'(Done), 0);
        check("b2b busy", int'(Busy), 1);
        @(posedge Clk); #1;
        check("b2b result", int'(ShiftedB), 16'h0002);
        check("b2b done", int'(Done), 1);
        // Back-to-back with zero distance keeps Done high for the new result.
        drive_req(16'h5555, 0, 3'b000);
        @(posedge Clk); #1;
        Start = 1'b0;
        check("b2b_sa0 done", int'(Done), 1);
        check("b2b_sa0 result", int'(ShiftedB), 16'h5555);
        @(posedge Clk); #1;
        check("b2b_sa0 done_drop", int'(Done), 0);

        // Reset on the 5th shifting edge of a 10-position operation.
        @(negedge Clk);
        drive_req(16'hD000, 10, 3'b000);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("abort ShiftedB", int'(ShiftedB), 0);
        check("abort Busy", int'(Busy), 0);
        check("abort Done", int'(Done), 0);
        saw_done = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            saw_done |= int'(Done) | int'(Busy);
        end
        check("abort no_done", saw_done, 0);
        op_and_check("after_abort", 16'hD000, 10, 3'b100, 16'hFFF4);

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [15:0] b;
            int sa;
            logic [2:0] sel;
            b = 16'($urandom);
            sa = int'($urandom_range(0, 15));
            sel = 3'($urandom_range(0, 7));
            do_op(b, sa, sel, res, lat, bn);
            check($sformatf("rand%0d result", k), int'(res), int'(ref_shift(b, sa, sel)));
            check($sformatf("rand%0d latency", k), lat, ref_lat(sa, sel));
            check($sformatf("rand%0d busy", k), bn, ref_lat(sa, sel));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, data width of OriginB/ShiftedB.
REQ-002 The module SHALL have parameter AMT_W, default 4, width of ShifterAmount (shift range 0..2^AMT_W-1).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request strobe; sampled only while Busy=0.
REQ-006 ShiftSelect  input  3  operation: 000 logical right, 001 logical left, 010 rotate right, 011 rotate left, 100 arithmetic right, 101-111 pass-through.
REQ-007 ShifterAmount  input  AMT_W  shift distance.
REQ-008 OriginB  input  WIDTH  operand.
REQ-009 ShiftedB  output  WIDTH  result register; valid when Done=1 and held until next accepted Start.
REQ-010 Busy  output  1  high while an operation is shifting.
REQ-011 Done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 On an edge with Start=1 in IDLE or DONE, the block SHALL capture ShiftSelect, OriginB into ShiftedB, and load counter Cnt with ShifterAmount.
REQ-014 Capture with Cnt load 0, or ShiftSelect 101-111, SHALL go directly to DONE with ShiftedB=OriginB.
REQ-015 Capture with nonzero amount and valid select SHALL go to SHIFT.
REQ-016 Each edge in SHIFT SHALL move ShiftedB one position per captured select and decrement Cnt; the edge at which Cnt is 1 SHALL transition to DONE.
REQ-017 Logical shifts SHALL fill with 0; rotates SHALL wrap the exiting bit; arithmetic right SHALL replicate bit WIDTH-1.
REQ-018 Done SHALL rise on capture edge + SA (SA=0: the capture edge itself) and stay high exactly one cycle unless a new Start is captured in DONE.
REQ-019 Busy SHALL equal (state==SHIFT); Start while Busy=1 SHALL be ignored with no state change.
REQ-020 Start in DONE SHALL be accepted (back-to-back); Done deasserts on that edge unless the new operation has SA=0, in which case Done stays high for the new result.
REQ-021 DONE without Start SHALL return to IDLE on the next edge; ShiftedB SHALL retain its value in IDLE.
REQ-022 Input changes after the capture edge SHALL NOT affect the operation in progress.

Reset
REQ-023 Reset=1 at an edge SHALL force state IDLE, ShiftedB=0, Cnt=0, Busy=0, Done=0, overriding Start.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no Done pulse.

Configuration
REQ-025 Macro ITERATIVE_SHIFTER_FAST2_EN SHALL, when defined, make SHIFT move two positions per edge while Cnt>=2 (Cnt decremented by 2) and one position when Cnt=1; Done rises at capture edge + ceil(SA/2).
REQ-026 Without ITERATIVE_SHIFTER_FAST2_EN the block SHALL shift one position per edge exactly as REQ-016; results SHALL be bit-identical in both builds.

Verification
REQ-027 OriginB=0xD000, SA=15, select 000 -> ShiftedB=0x0001, Done 15 edges after capture, Busy high 15 cycles.
REQ-028 OriginB=0xD000, SA=15, selects 001/010/011/100 -> 0x0000 / 0xA001 / 0x6800 / 0xFFFF.
REQ-029 SA=0 and select 110 with OriginB=0x1234 -> ShiftedB=0x1234, Done on capture edge, Busy never high.
REQ-030 Start held high during SHIFT with different operands -> ignored; back-to-back Start in DONE (0x0001, SA=1, select 001) -> 0x0002 one edge later.
REQ-031 Reset asserted at 5th SHIFT edge of a SA=10 operation -> ShiftedB=0, Busy=0, no Done pulse; next op completes normally.
REQ-032 With ITERATIVE_SHIFTER_FAST2_EN, 0xD000 SA=15 select 100 -> 0xFFFF, Done 8 edges after capture.
